id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage RV32I core.

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core, with EX-stage operand
// forwarding from MEM/WB and load-use bubble insertion.
module id_ex_stage #(
    parameter int Bits = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic [Bits-1:0] RD1D,
    input  logic [Bits-1:0] RD2D,
    input  logic [Bits-1:0] PCD,
    input  logic [Bits-1:0] ImmExtD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            ASrcD,
    input  logic            BSrcD,
    input  logic [3:0]      OpCodeD,
    input  logic [2:0]      BranchTypeD,
    input  logic            BranchD,
    input  logic            RegWriteD,
    input  logic            MemReadD,
    input  logic            MemWriteD,
    input  logic            FlushE,
    input  logic            StallE,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [Bits-1:0] ALUResultM,
    input  logic [Bits-1:0] ResultW,
    output logic [Bits-1:0] SrcAE,
    output logic [Bits-1:0] SrcBE,
    output logic [Bits-1:0] WriteDataE,
    output logic [3:0]      OpCodeE,
    output logic [2:0]      BranchTypeE,
    output logic            BranchE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic            MemWriteE,
    output logic            ValidE,
    output logic [4:0]      RdE,
    output logic [Bits-1:0] PCE,
    output logic            StallD
);

    logic            valid_e;
    logic [Bits-1:0] rd1_e, rd2_e, pc_e, imm_e;
    logic [4:0]      rs1_e, rs2_e, rd_e;
    logic            asrc_e, bsrc_e;
    logic [3:0]      opcode_e;
    logic [2:0]      btype_e;
    logic            branch_e, regwrite_e, memread_e, memwrite_e;

    logic            load_use;
    logic [Bits-1:0] fwd_a, fwd_b;

    // Handshake: ValidD/ValidE mark a real instruction in each slot; StallD is
    // the hold request back to IF/ID and is asserted in the same cycle it applies.
    assign load_use = ValidD & valid_e & memread_e & (rd_e != 5'd0) &
                      ((rd_e == Rs1D) | (rd_e == Rs2D));
    assign StallD   = load_use | StallE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_e    <= 1'b0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            pc_e       <= '0;
            imm_e      <= '0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            asrc_e     <= 1'b0;
            bsrc_e     <= 1'b0;
            opcode_e   <= 4'd0;
            btype_e    <= 3'd0;
            branch_e   <= 1'b0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            memwrite_e <= 1'b0;
        end else if (FlushE || (!StallE && load_use)) begin
            // Bubble: only the controls and destination are cleared; data fields are left as-is.
            valid_e    <= 1'b0;
            rd_e       <= 5'd0;
            branch_e   <= 1'b0;
            regwrite_e <= 1'b0;
            memread_e  <= 1'b0;
            memwrite_e <= 1'b0;
        end else if (!StallE) begin
            valid_e    <= ValidD;
            rd1_e      <= RD1D;
            rd2_e      <= RD2D;
            pc_e       <= PCD;
            imm_e      <= ImmExtD;
            rs1_e      <= Rs1D;
            rs2_e      <= Rs2D;
            rd_e       <= RdD;
            asrc_e     <= ASrcD;
            bsrc_e     <= BSrcD;
            opcode_e   <= OpCodeD;
            btype_e    <= BranchTypeD;
            branch_e   <= BranchD;
            regwrite_e <= RegWriteD;
            memread_e  <= MemReadD;
            memwrite_e <= MemWriteD;
        end
    end

    // MEM beats WB; x0 never forwards.
    always_comb begin
        fwd_a = rd1_e;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs1_e)) begin
            fwd_a = ALUResultM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs1_e)) begin
            fwd_a = ResultW;
        end
    end

    always_comb begin
        fwd_b = rd2_e;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs2_e)) begin
            fwd_b = ALUResultM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs2_e)) begin
            fwd_b = ResultW;
        end
    end

    assign SrcAE       = asrc_e ? pc_e : fwd_a;
    assign SrcBE       = bsrc_e ? imm_e : fwd_b;
    assign WriteDataE  = fwd_b;
    assign OpCodeE     = opcode_e;
    assign BranchTypeE = btype_e;
    assign BranchE     = branch_e;
    assign RegWriteE   = regwrite_e;
    assign MemReadE    = memread_e;
    assign MemWriteE   = memwrite_e;
    assign ValidE      = valid_e;
    assign RdE         = rd_e;
    assign PCE         = pc_e;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against a transaction-level model of the EX slot.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidD;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ASrcD, BSrcD;
    logic [3:0]  OpCodeD;
    logic [2:0]  BranchTypeD;
    logic        BranchD, RegWriteD, MemReadD, MemWriteD;
    logic        FlushE, StallE;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCE;
    logic [3:0]  OpCodeE;
    logic [2:0]  BranchTypeE;
    logic        BranchE, RegWriteE, MemReadE, MemWriteE, ValidE, StallD;
    logic [4:0]  RdE;

    int tests_run = 0;
    int fails = 0;

    id_ex_stage #(.Bits(32)) dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D),
        .PCD(PCD), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ASrcD(ASrcD), .BSrcD(BSrcD), .OpCodeD(OpCodeD), .BranchTypeD(BranchTypeD),
        .BranchD(BranchD), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .MemWriteD(MemWriteD), .FlushE(FlushE), .StallE(StallE), .RdM(RdM),
        .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .WriteDataE(WriteDataE), .OpCodeE(OpCodeE), .BranchTypeE(BranchTypeE),
        .BranchE(BranchE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .MemWriteE(MemWriteE), .ValidE(ValidE), .RdE(RdE), .PCE(PCE), .StallD(StallD)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // One record describing the instruction occupying EX; known=0 means its
    // data fields are don't-care (after a bubble).
    typedef struct packed {
        logic        valid, known;
        logic [31:0] rd1, rd2, pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        asrc, bsrc, br, rw, mr, mw;
        logic [3:0]  op;
        logic [2:0]  bt;
    } e_t;

    e_t m;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (RegWriteM && RdM != 0 && RdM == rs) return ALUResultM;
        if (RegWriteW && RdW != 0 && RdW == rs) return ResultW;
        return regval;
    endfunction

    function automatic logic model_load_use();
        return ValidD && m.valid && m.mr && m.rd != 0 && (m.rd == Rs1D || m.rd == Rs2D);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_check();
        check("ValidE", ValidE, m.valid);
        check("RegWriteE", RegWriteE, m.rw);
        check("MemReadE", MemReadE, m.mr);
        check("MemWriteE", MemWriteE, m.mw);
        check("BranchE", BranchE, m.br);
        check("RdE", RdE, m.rd);
        check("StallD", StallD, model_load_use() || StallE);
        if (m.known) begin
            check("OpCodeE", OpCodeE, m.op);
            check("BranchTypeE", BranchTypeE, m.bt);
            check("PCE", PCE, m.pc);
            check("SrcAE", SrcAE, m.asrc ? m.pc : fwd(m.rs1, m.rd1));
            check("SrcBE", SrcBE, m.bsrc ? m.imm : fwd(m.rs2, m.rd2));
            check("WriteDataE", WriteDataE, fwd(m.rs2, m.rd2));
        end
    endtask

    function automatic e_t bubble_of(input e_t cur);
        e_t n = cur;
        n.valid = 0; n.known = 0; n.rd = 0;
        n.br = 0; n.rw = 0; n.mr = 0; n.mw = 0;
        return n;
    endfunction

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic step();
        e_t n;
        logic captured;
        @(negedge clk);
        model_check();
        captured = 0;
        if (!rst_n) begin
            n = '0;
            n.known = 1;
        end else if (FlushE) begin
            n = bubble_of(m);
        end else if (StallE) begin
            n = m;
        end else if (model_load_use()) begin
            n = bubble_of(m);
        end else begin
            n.valid = ValidD; n.known = 1;
            n.rd1 = RD1D; n.rd2 = RD2D; n.pc = PCD; n.imm = ImmExtD;
            n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
            n.asrc = ASrcD; n.bsrc = BSrcD; n.br = BranchD; n.rw = RegWriteD;
            n.mr = MemReadD; n.mw = MemWriteD; n.op = OpCodeD; n.bt = BranchTypeD;
            exp_q.push_back(PCD);
            captured = 1;
        end
        @(posedge clk);
        #1;
        m = n;
        if (captured) begin
            if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
            else check("PCE_latency", PCE, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        ValidD = 0; RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; ASrcD = 0; BSrcD = 0;
        OpCodeD = 0; BranchTypeD = 0; BranchD = 0;
        RegWriteD = 0; MemReadD = 0; MemWriteD = 0;
        FlushE = 0; StallE = 0;
        RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
        ALUResultM = 0; ResultW = 0;
    endtask

    task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic rw);
        ValidD = v; Rs1D = rs1; Rs2D = rs2; RdD = rd; MemReadD = mr; RegWriteD = rw;
    endtask

    task automatic drive_random();
        ValidD = 1'($urandom_range(0, 5) != 0);
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
        Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
        RdD = 5'($urandom_range(0, 7));
        ASrcD = 1'($urandom); BSrcD = 1'($urandom);
        OpCodeD = 4'($urandom); BranchTypeD = 3'($urandom);
        BranchD = 1'($urandom); RegWriteD = 1'($urandom);
        MemReadD = 1'($urandom_range(0, 2) == 0); MemWriteD = 1'($urandom);
        FlushE = 1'($urandom_range(0, 7) == 0);
        StallE = 1'($urandom_range(0, 5) == 0);
        RdM = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        ALUResultM = $urandom; ResultW = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        m = '0;
        // Reset with D active.
        rst_n = 0;
        drive_d(1, 5'd1, 5'd2, 5'd3, 1, 1);
        PCD = 32'h100;
        @(posedge clk);
        #1;
        m = '0;
        m.known = 1;
        check("rst_ValidE", ValidE, 0);
        check("rst_RegWriteE", RegWriteE, 0);
        check("rst_RdE", RdE, 0);
        check("rst_StallD", StallD, 0);
        step();
        rst_n = 1;

        // MEM priority over WB.
        clear_inputs();
        drive_d(1, 5'd5, 5'd6, 5'd4, 0, 1);
        RD1D = 32'h99;
        step();
        ValidD = 0;
        RdM = 5; RegWriteM = 1; ALUResultM = 32'h11;
        RdW = 5; RegWriteW = 1; ResultW = 32'h22;
        #1;
        check("mem_prio", SrcAE, 32'h11);
        RegWriteM = 0;
        #1;
        check("wb_fwd", SrcAE, 32'h22);
        step();

        // x0 is never forwarded.
        clear_inputs();
        drive_d(1, 5'd3, 5'd0, 5'd4, 0, 1);
        step();
        ValidD = 0;
        RdM = 0; RegWriteM = 1; ALUResultM = 32'hDEAD;
        #1;
        check("x0_SrcBE", SrcBE, 0);
        check("x0_WriteDataE", WriteDataE, 0);
        step();

        // Load-use: lw x7 followed by add using x7.
        clear_inputs();
        drive_d(1, 5'd1, 5'd0, 5'd7, 1, 1);
        step();
        drive_d(1, 5'd7, 5'd2, 5'd8, 0, 1);
        RD1D = 32'h1234;
        #1;
        check("lu_StallD", StallD, 1);
        step();
        RdM = 7; RegWriteM = 1; ALUResultM = 32'h77;
        #1;
        check("lu_bubble_ValidE", ValidE, 0);
        check("lu_StallD_release", StallD, 0);
        step();
        #1;
        check("lu_add_ValidE", ValidE, 1);
        check("lu_add_RdE", RdE, 8);
        check("lu_add_fwd", SrcAE, 32'h77);
        step();

        // Flush wins over stall and load-use.
        clear_inputs();
        drive_d(1, 5'd1, 5'd0, 5'd7, 1, 1);
        BranchD = 1;
        step();
        drive_d(1, 5'd7, 5'd0, 5'd8, 0, 1);
        BranchD = 1;
        StallE = 1; FlushE = 1;
        #1;
        check("fl_StallD", StallD, 1);
        step();
        check("fl_ValidE", ValidE, 0);
        check("fl_BranchE", BranchE, 0);

        // Hold for three cycles, then capture the waiting D contents.
        clear_inputs();
        drive_d(1, 5'd1, 5'd2, 5'd9, 0, 1);
        OpCodeD = 4'b0001;
        step();
        StallE = 1;
        drive_d(1, 5'd3, 5'd4, 5'd10, 0, 1);
        OpCodeD = 4'b0110; PCD = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_OpCodeE", OpCodeE, 4'b0001);
            check("hold_RdE", RdE, 9);
            check("hold_StallD", StallD, 1);
            step();
        end
        StallE = 0;
        step();
        check("rel_OpCodeE", OpCodeE, 4'b0110);
        check("rel_RdE", RdE, 10);
        check("rel_PCE", PCE, 32'h500);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
